data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Parametrised data memory with a memory-mapped peripheral register window, for the pipelined MIPS
//  core's MEM stage. Adds byte-enable writes, registered 1-cycle reads with valid/ready handshake,
//  and a post-reset sequential RAM-clear engine. MMIO registers drive peripherals (LEDs, digit tube,
//  timer).
// PARAMETERS
//  RAM_DEPTH_LOG2  8              log2 of RAM words; RAM_DEPTH = 2**RAM_DEPTH_LOG2
//  MMIO_BASE       32'h4000_0000  byte base of MMIO window; aligned to MMIO_REGS*4
//  MMIO_REGS_LOG2  3              log2 of 32-bit MMIO registers; MMIO_REGS = 2**MMIO_REGS_LOG2
//  CLEAR_ON_RESET  1              1: zero every RAM word after reset; 0: skip the clear
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             asynchronous, active-high
//  req_valid  in   1             request present
//  req_ready  out  1             block accepts a request this cycle
//  req_we     in   1             1 = write, 0 = read
//  req_addr   in   32            byte address; bits [1:0] ignored
//  req_wdata  in   32            write data
//  req_be     in   4             byte enables; be[k] selects wdata[8k+7:8k]
//  rsp_valid  out  1             one-cycle pulse, one per accepted request
//  rsp_rdata  out  32            read data; 0 for write responses
//  rsp_err    out  1             address fault (see CONFIGURATION); valid with rsp_valid
//  init_busy  out  1             RAM clear in progress
//  mmio_q     out  32*MMIO_REGS  MMIO register contents; reg i at [32i+31:32i]
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all MMIO regs=0,
//    clear counter=0. RAM has no asynchronous reset.
//  - FSM: INIT -> IDLE. Reset enters INIT if CLEAR_ON_RESET=1, else IDLE.
//    INIT: init_busy=1, req_ready=0; write 0 to RAM[cnt] each cycle, cnt++; on cnt==RAM_DEPTH-1
//    go to IDLE. INIT takes exactly RAM_DEPTH cycles.
//    IDLE: init_busy=0, req_ready=1; accepts one request per cycle (back-to-back allowed).
//  - Accept = req_valid & req_ready at a clk edge.
//  - Decode: MMIO hit when (req_addr & ~(MMIO_REGS*4-1)) == MMIO_BASE; index =
//    addr[MMIO_REGS_LOG2+1:2]. Otherwise RAM, index = addr[RAM_DEPTH_LOG2+1:2].
//  - Write: bytes with be[k]=1 are updated at the accept edge; others are kept.
//    be=4'b0000 changes nothing but is still acknowledged.
//  - Response: rsp_valid=1 the cycle after accept. For reads, rsp_rdata holds the full 32-bit word
//    as of the accept edge. A read accepted on the cycle after a write to the same word returns
//    the new data. A read and a write are never accepted on the same edge.
//  - Reset asserted mid-INIT restarts the clear from 0. Reset mid-transaction drops the pending
//    response (rsp_valid=0). A write at the accept edge coinciding with reset is discarded.
//  - req_valid while req_ready=0 is ignored; the requester must hold it.
// CONFIGURATION
//  ADDR_FAULT_EN defined: a non-MMIO address with any bit in [31:RAM_DEPTH_LOG2+2] set is a fault.
//  Writes are suppressed; reads return 32'hDEAD_BEEF; rsp_err=1 with rsp_valid.
//  ADDR_FAULT_EN undefined: the upper bits are ignored (RAM aliases with wrap-around);
//  rsp_err is tied 0.
// STRUCTURE
//  Package data_mem_pkg: state enum {ST_INIT, ST_IDLE}, DEFAULT_MMIO_BASE, FAULT_DATA=32'hDEAD_BEEF,
//  function be_merge(old, wdata, be).
//  Sub-module mmio_regfile: MMIO_REGS async-reset registers with byte-enable write and flat
//  mmio_q output. The RAM array, clear FSM and response register stay in data_mem_mmio.
// TESTING
//  1. Reset, CLEAR_ON_RESET=1, depth 256 -> init_busy high for exactly 256 cycles, then
//     req_ready=1; read addr 0x3FC -> rsp 0.
//  2. Write 0x11223344 be=1111 to 0x10, then write 0xAABBCCDD be=0101 to 0x10, then read 0x10
//     -> 0x11BB33DD, each rsp_valid one cycle after its accept.
//  3. Write 0x0000_00FF to MMIO_BASE+0xC -> mmio_q[127:96]=0xFF; read it back -> 0xFF;
//     RAM word 3 unchanged.
//  4. Back-to-back write 0x5 to 0x20 then read 0x20 -> read rsp 0x5 the cycle after the read
//     accept; 2 responses in 2 consecutive cycles.
//  5. Assert reset at cycle 100 of INIT -> clear restarts; init_busy lasts a full 256 cycles after
//     release; MMIO regs read 0.
//  6. Read 0x0000_0400 (beyond 256 words): with ADDR_FAULT_EN -> rdata 0xDEADBEEF, rsp_err=1.
//     Without -> aliases word 0, rsp_err=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory with MMIO window.
package data_mem_pkg;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h4000_0000;
  localparam logic [31:0] FAULT_DATA        = 32'hDEAD_BEEF;

  // Replace the bytes of old_word selected by be with the matching bytes of wdata.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mmio_regfile.sv
// Bank of 32-bit memory-mapped peripheral registers with byte-enable writes.
// Register i is presented on q[32i+31:32i].
module mmio_regfile
  import data_mem_pkg::*;
#(
  parameter int REGS_LOG2 = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [REGS_LOG2-1:0]          idx,
  input  logic [31:0]                   wdata,
  input  logic [3:0]                    be,
  output logic [32*(2**REGS_LOG2)-1:0]  q
);

  localparam int REGS = 2**REGS_LOG2;

  logic [31:0] regs [REGS];

  // Peripheral registers: cleared by reset, byte-merged on a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[idx] <= be_merge(regs[idx], wdata, be);
    end
  end

  for (genvar i = 0; i < REGS; i++) begin : g_flat
    assign q[32*i +: 32] = regs[i];
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory for the MEM stage: word RAM with byte-enable writes, registered
// one-cycle responses, a post-reset clear engine and an MMIO register window.
// Optional build macro ADDR_FAULT_EN: RAM addresses with upper bits set fault
// (write suppressed, read returns FAULT_DATA, rsp_err raised); without it the
// upper bits are ignored and the RAM aliases.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int          RAM_DEPTH_LOG2 = 8,
  parameter logic [31:0] MMIO_BASE      = DEFAULT_MMIO_BASE,
  parameter int          MMIO_REGS_LOG2 = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_we,
  input  logic [31:0]                        req_addr,
  input  logic [31:0]                        req_wdata,
  input  logic [3:0]                         req_be,
  output logic                               rsp_valid,
  output logic [31:0]                        rsp_rdata,
  output logic                               rsp_err,
  output logic                               init_busy,
  output logic [32*(2**MMIO_REGS_LOG2)-1:0]  mmio_q
);

  localparam int          RAM_DEPTH = 2**RAM_DEPTH_LOG2;
  localparam int          MMIO_REGS = 2**MMIO_REGS_LOG2;
  localparam logic [31:0] MMIO_MASK = ~(32'(MMIO_REGS * 4) - 32'd1);
  localparam logic [RAM_DEPTH_LOG2-1:0] RAM_LAST = '1;

  logic [31:0]               ram [RAM_DEPTH];
  state_t                    state;
  logic [RAM_DEPTH_LOG2-1:0] cnt;

  logic                      accept;
  logic                      mmio_hit;
  logic                      fault;
  logic                      ram_we;
  logic                      mmio_we;
  logic [RAM_DEPTH_LOG2-1:0] ram_idx;
  logic [MMIO_REGS_LOG2-1:0] mmio_idx;
  logic [31:0]               rd_word;
  logic [31:0]               mmio_words [MMIO_REGS];
  logic                      unused_addr;

  assign accept   = req_valid & req_ready;
  assign mmio_hit = (req_addr & MMIO_MASK) == MMIO_BASE;
  assign ram_idx  = req_addr[RAM_DEPTH_LOG2+1:2];
  assign mmio_idx = req_addr[MMIO_REGS_LOG2+1:2];

`ifdef ADDR_FAULT_EN
  assign fault = ~mmio_hit & (|req_addr[31:RAM_DEPTH_LOG2+2]);
`else
  assign fault = 1'b0;
`endif

  // Byte-offset bits never select anything; upper bits only matter for faults.
  assign unused_addr = ^{req_addr[1:0], req_addr[31:RAM_DEPTH_LOG2+2]};

  // req_ready drops asynchronously with reset, so a write can never be
  // accepted on an edge that coincides with reset.
  assign ram_we  = accept & req_we & ~mmio_hit & ~fault;
  assign mmio_we = accept & req_we & mmio_hit;

  mmio_regfile #(
    .REGS_LOG2 (MMIO_REGS_LOG2)
  ) u_mmio (
    .clk   (clk),
    .reset (reset),
    .we    (mmio_we),
    .idx   (mmio_idx),
    .wdata (req_wdata),
    .be    (req_be),
    .q     (mmio_q)
  );

  for (genvar i = 0; i < MMIO_REGS; i++) begin : g_words
    assign mmio_words[i] = mmio_q[32*i +: 32];
  end

  // Read word selection: fault pattern, MMIO register or RAM word.
  always_comb begin
    // NOTE: every path assigns rd_word, so no latch is inferred.
    rd_word = ram[ram_idx];
    if (fault)         rd_word = FAULT_DATA;
    else if (mmio_hit) rd_word = mmio_words[mmio_idx];
  end

  // Clear/idle FSM with registered handshake and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_busy <= CLEAR_ON_RESET;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == RAM_LAST) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // RAM array: sequential clear during INIT, byte-merged writes when idle.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset so it can map onto block memory; the clear
    // engine zeroes it word by word instead.
    if (state == ST_INIT)  ram[cnt]     <= '0;
    else if (ram_we)       ram[ram_idx] <= be_merge(ram[ram_idx], req_wdata, req_be);
  end

  // Response register: one pulse per accepted request, data only for reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_rdata <= (accept & ~req_we) ? rd_word : 32'd0;
    end
  end

`ifdef ADDR_FAULT_EN
  // Fault flag travels with the response pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err <= 1'b0;
    else       rsp_err <= accept & fault;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: reset/clear timing, a table of
// back-to-back requests scored through a response queue, and reset corner cases.
module tb_data_mem_mmio;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef ADDR_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         init_busy;
  logic [255:0] mmio_q;

  data_mem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy),
    .mmio_q    (mmio_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[18];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response is matched in order against the queue,
  // including the cycle it must appear on.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h with empty queue", rsp_rdata);
      end else begin
        e = sb.pop_front();
        check({e.name, "_rdata"}, rsp_rdata, e.rdata);
        check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Present one request for one cycle; called at a negedge, returns at the next.
  task automatic drive(input vec_t v);
    exp_t x;
    int   n = 0;
    while (!req_ready && n < 1000) begin
      req_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({v.name, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
    end else begin
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      x.rdata = v.exp_rdata;
      x.err   = v.exp_err;
      x.due   = cyc + 1;
      x.name  = v.name;
      sb.push_back(x);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count negedge samples of init_busy high, starting at reset release.
  task automatic count_init(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_queue_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b0, 32'h0000_03FC, 32'h0,          4'b0000, 32'h0000_0000, 1'b0, "rd_last_word"};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0, "wr_full"};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0, "wr_be0101"};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,          4'b0000, 32'h11BB_33DD, 1'b0, "rd_merged"};
    vecs[4]  = '{1'b0, 32'h0000_000C, 32'h0,          4'b0000, 32'h0000_0000, 1'b0, "rd_word3_pre"};
    vecs[5]  = '{1'b1, BASE + 32'hC,  32'h0000_00FF, 4'b1111, 32'h0000_0000, 1'b0, "wr_mmio3"};
    vecs[6]  = '{1'b0, BASE + 32'hC,  32'h0,          4'b0000, 32'h0000_00FF, 1'b0, "rd_mmio3"};
    vecs[7]  = '{1'b0, 32'h0000_000C, 32'h0,          4'b0000, 32'h0000_0000, 1'b0, "rd_word3_post"};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'h0000_0005, 4'b1111, 32'h0000_0000, 1'b0, "wr_b2b"};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'h0000_0005, 1'b0, "rd_b2b"};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0, "wr_be0000"};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'h0000_0005, 1'b0, "rd_after_be0"};
    vecs[12] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0, "wr_word0"};
    vecs[13] = '{1'b0, 32'h0000_0400, 32'h0,          4'b0000,
                 FE ? 32'hDEAD_BEEF : 32'hCAFE_F00D, FE, "rd_beyond"};
    vecs[14] = '{1'b1, 32'h0000_0404, 32'h1234_5678, 4'b1111, 32'h0000_0000, FE, "wr_beyond"};
    vecs[15] = '{1'b0, 32'h0000_0004, 32'h0,          4'b0000,
                 FE ? 32'h0000_0000 : 32'h1234_5678, 1'b0, "rd_word1"};
    vecs[16] = '{1'b1, BASE,          32'h0000_AB00, 4'b0010, 32'h0000_0000, 1'b0, "wr_mmio0_b1"};
    vecs[17] = '{1'b0, BASE,          32'h0,          4'b0000, 32'h0000_AB00, 1'b0, "rd_mmio0"};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset state and full-length clear.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_init_busy", {31'd0, init_busy}, 32'd1);
    check("rst_mmio_lo",   mmio_q[31:0], 32'd0);
    reset = 1'b0;
    count_init(n);
    check("init_len", 32'(n), 32'd256);
    check("init_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back table.
    for (int i = 0; i < 18; i++) drive(vecs[i]);
    drain("table");
    check("mmio_reg3", mmio_q[127:96], 32'h0000_00FF);
    check("mmio_reg0", mmio_q[31:0],   32'h0000_AB00);
    check("mmio_reg1", mmio_q[63:32],  32'h0000_0000);

    // Reset right after an accept drops the pending response.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0010;
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 1'b0;
    #1 check("rst_drops_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset in the middle of the clear restarts it from zero.
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_init_busy", {31'd0, init_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_init(n);
    check("reinit_len", 32'(n), 32'd256);
    check("reinit_mmio3", mmio_q[127:96], 32'd0);
    check("reinit_mmio0", mmio_q[31:0],   32'd0);

    drive('{1'b0, BASE + 32'hC,  32'h0, 4'b0000, 32'h0, 1'b0, "rd_mmio3_cleared"});
    drive('{1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 1'b0, "rd_ram_cleared"});
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
